// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: writeback (port A) has priority,
// multiply/divide results (port B) queue in a FIFO with a starvation guard.
module rf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_write,
  input  logic [4:0]  i_wb_register,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_stall,
  input  logic        i_mc_valid,
  input  logic [4:0]  i_mc_register,
  input  logic [31:0] i_mc_data,
  output logic        o_mc_ready,
  output logic        o_reg_write,
  output logic [4:0]  o_write_register,
  output logic [31:0] o_write_data,
  output logic [31:0] o_pending_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       reg_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [AW-1:0]    age_q;
  logic             stall_q;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic wb_grant;
  logic blocked;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign o_mc_ready = !reset && !full;
  assign o_wb_stall = stall_q;

  // Register-0 results are accepted but dropped here.
  assign push = i_mc_valid && o_mc_ready && (i_mc_register != 5'd0);

  // Any port A request (even to r0) blocks the head unless stalled.
  assign pop      = !empty && (stall_q || !i_wb_write);
  assign wb_grant = !reset && !stall_q && i_wb_write
                    && (i_wb_register != 5'd0);
  assign blocked  = !empty && !pop;

  always_comb begin
    o_reg_write      = pop || wb_grant;
    o_write_register = i_wb_register;
    o_write_data     = i_wb_data;
    if (pop) begin
      o_write_register = reg_q[rd_ptr_q];
      o_write_data     = data_q[rd_ptr_q];
    end
  end

  always_comb begin
    o_pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) o_pending_mask[reg_q[i]] = 1'b1;
    end
    o_pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[wr_ptr_q]  <= i_mc_register;
      data_q[wr_ptr_q] <= i_mc_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      if (!blocked) age_q <= '0;
      else          age_q <= age_q + 1'b1;
      stall_q <= blocked && !stall_q
                 && (age_q == AW'(STARVE_LIMIT - 1));
    end
  end

endmodule
